serial_tx_controller: RTL and testbench

- Transmit-side counterpart of the oversampled serial receive path.
- Accepts a parallel byte on a load strobe and shifts it out LSB-first on a single line, framed as start bit 0, 8 data bits, stop bit 1.
- Bit timing is derived from the same oversampling tick enable (En) and period-trim input (m) used by the receive path, so both ends agree on bit length.
- Sits between the parallel data source and the serial output pin.

---
 rtl/serial_pkg.sv | 17 +
 rtl/bit_timer.sv | 40 ++++
 rtl/serial_tx_controller.sv | 154 +++++++++++++++
 tb/tb_serial_tx_controller.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit and receive controllers.
package serial_pkg;

    localparam int   DATA_W_DEF  = 8;
    localparam int   TICK_W_DEF  = 4;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts En ticks and flags the last tick of each bit period.
module bit_timer
    import serial_pkg::*;
#(
    parameter int TICK_W = TICK_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              En,
    input  logic              clr,
    input  logic [TICK_W-1:0] period,
    output logic              bit_end
);

    logic [TICK_W-1:0] tick_q;
    logic [TICK_W-1:0] tick_d;

    assign bit_end = En && (tick_q == period);

    // The counter wraps on the same edge that ends the bit.
    always_comb begin
        tick_d = tick_q;
        if (clr) begin
            tick_d = '0;
        end else if (bit_end) begin
            tick_d = '0;
        end else if (En) begin
            tick_d = tick_q + TICK_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/serial_tx_controller.sv
// Serial transmitter: start bit, DATA_W bits LSB-first, optional even parity, stop bit.
// Build with SERIAL_TX_PARITY_EN defined to insert the parity bit before the stop bit.
module serial_tx_controller
    import serial_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TICK_W = TICK_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              En,
    input  logic [TICK_W-1:0] m,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic              txd,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [TICK_W-1:0] period_q, period_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timer_clr;
    logic              bit_end;
`ifdef SERIAL_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    bit_timer #(
        .TICK_W (TICK_W)
    ) u_bit_timer (
        .Clk     (Clk),
        .Reset   (Reset),
        .En      (En),
        .clr     (timer_clr),
        .period  (period_q),
        .bit_end (bit_end)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        period_d  = period_q;
        bit_cnt_d = bit_cnt_q;
        timer_clr = 1'b0;
        done_d    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d   = START;
                    shift_d   = din;
                    // Terminal tick is 2^TICK_W-1-m, which is simply ~m.
                    period_d  = ~m;
                    bit_cnt_d = '0;
                    timer_clr = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d  = ^din;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level is derived from the next state so txd is a clean flop output.
    always_comb begin
        txd_d  = IDLE_LEVEL;
        busy_d = (state_d != IDLE);
        case (state_d)
            START:   txd_d = START_LEVEL;
            DATA:    txd_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY:  txd_d = parity_d;
`endif
            default: txd_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            period_q  <= '0;
            bit_cnt_q <= '0;
            txd_q     <= IDLE_LEVEL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            period_q  <= period_d;
            bit_cnt_q <= bit_cnt_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_tx_controller.sv
// Directed bench for serial_tx_controller; a frame-level tick model predicts txd/busy/done every cycle.
module tb_serial_tx_controller;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       En;
    logic [3:0] m;
    logic       load;
    logic [7:0] din;
    logic       txd;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    serial_tx_controller #(
        .DATA_W (8),
        .TICK_W (4)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .En    (En),
        .m     (m),
        .load  (load),
        .din   (din),
        .txd   (txd),
        .busy  (busy),
        .done  (done)
    );

    task automatic checkOutput(input string tag, input int cyc,
                               input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: observed %0h, expected %0h", tag, cyc, observed, expected);
        end
    endtask

    // Sends one frame starting at the current negedge and checks every cycle until done.
    // The model counts En ticks seen since the accept edge; bit index = ticks / bit length.
    task automatic applyStimulus(input logic [7:0] data, input logic [3:0] trim, input int en_div,
                                 input int pulse_cycle, input int freeze_start,
                                 input bit hold_next, input logic [7:0] next_data);
        logic frame_bits [0:11];
        int   nbits;
        int   len;
        int   total;
        int   ticks;
        int   k;
        int   c;
        bit   fin;
        bit   frozen;

        frame_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) frame_bits[i+1] = data[i];
`ifdef SERIAL_TX_PARITY_EN
        frame_bits[9]  = ^data;
        frame_bits[10] = 1'b1;
        frame_bits[11] = 1'b1;
        nbits = 11;
`else
        frame_bits[9]  = 1'b1;
        frame_bits[10] = 1'b1;
        frame_bits[11] = 1'b1;
        nbits = 10;
`endif
        len   = 16 - int'(trim);
        total = nbits * len;

        load = 1'b1;
        din  = data;
        m    = trim;
        En   = 1'b1;
        @(posedge Clk);
        k = 0;
        ticks = 0;
        fin = 1'b0;
        while (!fin && k < 5000) begin
            @(negedge Clk);
            if (k > 0) begin
                if (ticks < total) begin
                    checkOutput("txd", k, 32'(txd), 32'(frame_bits[ticks / len]));
                    checkOutput("busy", k, 32'(busy), 32'd1);
                    checkOutput("done", k, 32'(done), 32'd0);
                end else begin
                    checkOutput("end_txd", k, 32'(txd), 32'd1);
                    checkOutput("end_busy", k, 32'(busy), 32'd0);
                    checkOutput("end_done", k, 32'(done), 32'd1);
                    checkOutput("frame_len", k, 32'(ticks), 32'(total));
                    fin = 1'b1;
                end
            end
            if (!fin) begin
                c = k + 1;
                frozen = (freeze_start > 0) && (c >= freeze_start) && (c < freeze_start + 50);
                En = ((c % en_div) == 0) && !frozen;
                m  = trim ^ 4'h9;
                if (c == pulse_cycle) begin
                    load = 1'b1;
                    din  = 8'hFF;
                end else if (hold_next && ticks >= total - len) begin
                    load = 1'b1;
                    din  = next_data;
                end else begin
                    load = 1'b0;
                    din  = 8'h00;
                end
                @(posedge Clk);
                k++;
                if (En) ticks++;
            end
        end
        if (!fin) checkOutput("timeout", k, 32'd0, 32'd1);
    endtask

    task automatic idle_check(input string tag);
        load = 1'b0;
        En   = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        checkOutput({tag, "_txd"}, 0, 32'(txd), 32'd1);
        checkOutput({tag, "_busy"}, 0, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 0, 32'(done), 32'd0);
    endtask

    initial begin
        Reset = 1'b1;
        En    = 1'b1;
        load  = 1'b0;
        m     = 4'd0;
        din   = 8'h00;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checkOutput("rst_txd", 0, 32'(txd), 32'd1);
        checkOutput("rst_busy", 0, 32'(busy), 32'd0);
        checkOutput("rst_done", 0, 32'(done), 32'd0);
        Reset = 1'b0;

        applyStimulus(8'hA5, 4'd0, 1, 0, 0, 1'b0, 8'h00);
        idle_check("a5_idle");
        applyStimulus(8'h00, 4'd15, 1, 0, 0, 1'b0, 8'h00);
        idle_check("fast_idle");
        applyStimulus(8'h3C, 4'd12, 4, 0, 60, 1'b0, 8'h00);
        idle_check("freeze_idle");
        applyStimulus(8'h5A, 4'd0, 1, 30, 0, 1'b1, 8'hC3);
        applyStimulus(8'hC3, 4'd3, 1, 0, 0, 1'b0, 8'h00);
        idle_check("b2b_idle");

        // Abandon a frame during data bit 3 (ticks 64..79 at m=0).
        load = 1'b1;
        din  = 8'hA5;
        m    = 4'd0;
        En   = 1'b1;
        @(posedge Clk);
        for (int i = 0; i < 70; i++) begin
            @(negedge Clk);
            load = 1'b0;
            @(posedge Clk);
        end
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        checkOutput("midrst_txd", 0, 32'(txd), 32'd1);
        checkOutput("midrst_busy", 0, 32'(busy), 32'd0);
        checkOutput("midrst_done", 0, 32'(done), 32'd0);
        Reset = 1'b0;
        applyStimulus(8'h96, 4'd5, 1, 0, 0, 1'b0, 8'h00);
        idle_check("after_rst_idle");

`ifdef SERIAL_TX_PARITY_EN
        applyStimulus(8'h07, 4'd0, 1, 0, 0, 1'b0, 8'h00);
        idle_check("par1_idle");
        applyStimulus(8'h03, 4'd0, 1, 0, 0, 1'b0, 8'h00);
        idle_check("par0_idle");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
